// File: rtl/conv_addr_sequencer.sv
// Convolution address/enable sequencer: LOAD_W -> LOAD_I -> COMPUTE -> STORE_O per block, then FLUSH/DONE.
// Optional macro CONV_SEQ_WEIGHT_REUSE_EN: load weights only for block 0.
module conv_addr_sequencer #(
    parameter int AddressWidth  = 32,
    parameter int W_PEGroupSize = 4,
    parameter int O_PEGroupSize = 4,
    parameter int I_PEGroupSize = W_PEGroupSize + O_PEGroupSize - 1,
    parameter int BlockCount    = 4,
    parameter int ComputeCycles = 11,
    parameter int CntWidth      = 8
) (
    input  logic                    clk,
    input  logic                    aclr,
    input  logic                    start,
    input  logic [AddressWidth-1:0] W_Base,
    input  logic [AddressWidth-1:0] I_Base,
    input  logic [AddressWidth-1:0] O_Base,
    output logic                    busy,
    output logic                    done,
    output logic [AddressWidth-1:0] OFF_W_RAddr,
    output logic [AddressWidth-1:0] OFF_I_RAddr,
    output logic                    ON_W_WEn,
    output logic [AddressWidth-1:0] ON_W_WAddr,
    output logic                    ON_I_WEn,
    output logic [AddressWidth-1:0] ON_I_WAddr,
    output logic [AddressWidth-1:0] ON_O_RAddr,
    output logic                    OFF_O_WEn,
    output logic [AddressWidth-1:0] OFF_O_WAddr
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_I, S_COMPUTE, S_STORE_O, S_FLUSH, S_DONE
    } state_t;

    localparam logic [CntWidth-1:0]     W_LAST = CntWidth'(W_PEGroupSize - 1);
    localparam logic [CntWidth-1:0]     I_LAST = CntWidth'(I_PEGroupSize - 1);
    localparam logic [CntWidth-1:0]     C_LAST = CntWidth'(ComputeCycles - 1);
    localparam logic [CntWidth-1:0]     O_LAST = CntWidth'(O_PEGroupSize - 1);
    localparam logic [CntWidth-1:0]     B_LAST = CntWidth'(BlockCount - 1);
    localparam logic [AddressWidth-1:0] STRIDE = AddressWidth'(O_PEGroupSize);

    state_t                  state, state_d;
    logic [CntWidth-1:0]     k, k_d, b, b_d;
    logic [AddressWidth-1:0] w_base, i_base, o_base, w_base_d, i_base_d, o_base_d;

    logic                    busy_nx, done_nx, on_w_wen_nx, on_i_wen_nx, off_o_wen_nx;
    logic [AddressWidth-1:0] off_w_raddr_nx, off_i_raddr_nx, on_o_raddr_nx;
    logic [AddressWidth-1:0] on_w_waddr_nx, on_i_waddr_nx, off_o_waddr_nx;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state  <= S_IDLE;
            k      <= '0;
            b      <= '0;
            w_base <= '0;
            i_base <= '0;
            o_base <= '0;
        end else begin
            state  <= state_d;
            k      <= k_d;
            b      <= b_d;
            w_base <= w_base_d;
            i_base <= i_base_d;
            o_base <= o_base_d;
        end
    end

    always_comb begin
        state_d  = state;
        k_d      = k;
        b_d      = b;
        w_base_d = w_base;
        i_base_d = i_base;
        o_base_d = o_base;
        case (state)
            S_IDLE: if (start) begin
                state_d  = S_LOAD_W;
                k_d      = '0;
                b_d      = '0;
                w_base_d = W_Base;
                i_base_d = I_Base;
                o_base_d = O_Base;
            end
            S_LOAD_W: if (k == W_LAST) begin
                state_d = S_LOAD_I;
                k_d     = '0;
            end else k_d = k + CntWidth'(1);
            S_LOAD_I: if (k == I_LAST) begin
                state_d = S_COMPUTE;
                k_d     = '0;
            end else k_d = k + CntWidth'(1);
            S_COMPUTE: if (k == C_LAST) begin
                state_d = S_STORE_O;
                k_d     = '0;
            end else k_d = k + CntWidth'(1);
            S_STORE_O: if (k == O_LAST) begin
                k_d = '0;
                if (b == B_LAST) state_d = S_FLUSH;
                else begin
                    b_d = b + CntWidth'(1);
`ifdef CONV_SEQ_WEIGHT_REUSE_EN
                    state_d = S_LOAD_I;
`else
                    state_d = S_LOAD_W;
`endif
                end
            end else k_d = k + CntWidth'(1);
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read addresses follow the upcoming state so they line up with it once registered;
    // the delayed writes trail the current read phase by exactly one cycle.
    always_comb begin
        busy_nx        = (state_d != S_IDLE) && (state_d != S_DONE);
        done_nx        = (state_d == S_DONE);
        off_w_raddr_nx = (state_d == S_LOAD_W) ? w_base_d + AddressWidth'(k_d) : OFF_W_RAddr;
        off_i_raddr_nx = (state_d == S_LOAD_I) ?
                         i_base_d + AddressWidth'(b_d) * STRIDE + AddressWidth'(k_d) : OFF_I_RAddr;
        on_o_raddr_nx  = (state_d == S_STORE_O) ? AddressWidth'(k_d) : ON_O_RAddr;
        on_w_wen_nx    = (state == S_LOAD_W);
        on_w_waddr_nx  = (state == S_LOAD_W) ? AddressWidth'(k) : ON_W_WAddr;
        on_i_wen_nx    = (state == S_LOAD_I);
        on_i_waddr_nx  = (state == S_LOAD_I) ? AddressWidth'(k) : ON_I_WAddr;
        off_o_wen_nx   = (state == S_STORE_O);
        off_o_waddr_nx = (state == S_STORE_O) ?
                         o_base + AddressWidth'(b) * STRIDE + AddressWidth'(k) : OFF_O_WAddr;
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            OFF_W_RAddr <= '0;
            OFF_I_RAddr <= '0;
            ON_O_RAddr  <= '0;
            ON_W_WEn    <= 1'b0;
            ON_W_WAddr  <= '0;
            ON_I_WEn    <= 1'b0;
            ON_I_WAddr  <= '0;
            OFF_O_WEn   <= 1'b0;
            OFF_O_WAddr <= '0;
        end else begin
            busy        <= busy_nx;
            done        <= done_nx;
            OFF_W_RAddr <= off_w_raddr_nx;
            OFF_I_RAddr <= off_i_raddr_nx;
            ON_O_RAddr  <= on_o_raddr_nx;
            ON_W_WEn    <= on_w_wen_nx;
            ON_W_WAddr  <= on_w_waddr_nx;
            ON_I_WEn    <= on_i_wen_nx;
            ON_I_WAddr  <= on_i_waddr_nx;
            OFF_O_WEn   <= off_o_wen_nx;
            OFF_O_WAddr <= off_o_waddr_nx;
        end
    end

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Directed bench for conv_addr_sequencer; cycle 1 is the cycle after the start-accept edge.
module tb_conv_addr_sequencer;

    logic        clk = 1'b0;
    logic        aclr = 1'b0;
    logic        start = 1'b0;
    logic [31:0] W_Base = '0, I_Base = '0, O_Base = '0;
    logic        busy, done, ON_W_WEn, ON_I_WEn, OFF_O_WEn;
    logic [31:0] OFF_W_RAddr, OFF_I_RAddr, ON_W_WAddr, ON_I_WAddr, ON_O_RAddr, OFF_O_WAddr;

    conv_addr_sequencer dut (
        .clk(clk), .aclr(aclr), .start(start),
        .W_Base(W_Base), .I_Base(I_Base), .O_Base(O_Base),
        .busy(busy), .done(done),
        .OFF_W_RAddr(OFF_W_RAddr), .OFF_I_RAddr(OFF_I_RAddr),
        .ON_W_WEn(ON_W_WEn), .ON_W_WAddr(ON_W_WAddr),
        .ON_I_WEn(ON_I_WEn), .ON_I_WAddr(ON_I_WAddr),
        .ON_O_RAddr(ON_O_RAddr),
        .OFF_O_WEn(OFF_O_WEn), .OFF_O_WAddr(OFF_O_WAddr)
    );

    always #5 clk = ~clk;

`ifdef CONV_SEQ_WEIGHT_REUSE_EN
    localparam int DONE_CYC = 94;
    localparam int W_WENS   = 4;
`else
    localparam int DONE_CYC = 106;
    localparam int W_WENS   = 16;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int done_cyc;

    logic [196:0] all_out;
    assign all_out = {busy, done, ON_W_WEn, ON_I_WEn, OFF_O_WEn, OFF_W_RAddr, OFF_I_RAddr,
                      ON_W_WAddr, ON_I_WAddr, ON_O_RAddr, OFF_O_WAddr};

    logic [31:0] r_wra [0:255];
    logic [31:0] r_ira [0:255];
    logic [31:0] r_wwa [0:255];
    logic [31:0] r_owa [0:255];
    logic        r_busy[0:255];
    logic        r_done[0:255];
    logic        r_wwe [0:255];
    logic        r_iwe [0:255];
    logic        r_owe [0:255];

    // First LOAD_I cycle of block b (cycle 1 = first LOAD_W cycle of block 0).
    function automatic int li_start(input int b);
`ifdef CONV_SEQ_WEIGHT_REUSE_EN
        return (b == 0) ? 5 : 27 + 22 * (b - 1);
`else
        return 26 * b + 5;
`endif
    endfunction

    function automatic int st_start(input int b);
        return li_start(b) + 7 + 11;
    endfunction

    // Starts a job and records outputs per cycle until `extra` cycles past done (bounded).
    task automatic run_job(input logic [31:0] wb, ib, ob, input bit hold, input int extra);
        @(negedge clk);
        W_Base = wb; I_Base = ib; O_Base = ob; start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        done_cyc = 0;
        for (int c = 1; c <= 250; c++) begin
            @(negedge clk);
            r_wra[c] = OFF_W_RAddr; r_ira[c] = OFF_I_RAddr; r_wwa[c] = ON_W_WAddr;
            r_owa[c] = OFF_O_WAddr; r_busy[c] = busy; r_done[c] = done;
            r_wwe[c] = ON_W_WEn; r_iwe[c] = ON_I_WEn; r_owe[c] = OFF_O_WEn;
            if (hold && c == 3) begin
                W_Base = 32'hDEAD0000; I_Base = 32'hBEEF0000; O_Base = 32'hCAFE0000;
            end
            if (done && done_cyc == 0) done_cyc = c;
            if (done_cyc != 0 && c >= done_cyc + extra) break;
        end
    endtask

    task automatic test_reset;
        aclr = 1'b0; start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (all_out !== '0) $display("FAIL reset_hold cyc %0d: outputs=%h want 0", c, all_out);
            else n_pass++;
        end
        aclr = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (all_out !== '0) $display("FAIL idle_zero cyc %0d: outputs=%h want 0", c, all_out);
            else n_pass++;
        end
    endtask

    task automatic test_single_job;
        int nw, ni, no, nd, busy_bad;
        run_job(32'h100, 32'h200, 32'h300, 1'b0, 1);
        n_checks++;
        if (done_cyc !== DONE_CYC) $display("FAIL done_cycle: got %0d want %0d", done_cyc, DONE_CYC);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (r_wra[1+k] !== 32'h100 + k) $display("FAIL w_raddr k=%0d: got %h want %h", k, r_wra[1+k], 32'h100 + k);
            else n_pass++;
            n_checks++;
            if (r_wwe[2+k] !== 1'b1 || r_wwa[2+k] !== k) $display("FAIL w_write k=%0d: wen=%b addr=%h want 1/%h", k, r_wwe[2+k], r_wwa[2+k], k);
            else n_pass++;
            n_checks++;
            if (r_ira[li_start(2)+k] !== 32'h208 + k) $display("FAIL i_raddr_blk2 k=%0d: got %h want %h", k, r_ira[li_start(2)+k], 32'h208 + k);
            else n_pass++;
            n_checks++;
            if (r_owe[st_start(3)+1+k] !== 1'b1 || r_owa[st_start(3)+1+k] !== 32'h30C + k)
                $display("FAIL o_write_blk3 k=%0d: wen=%b addr=%h want 1/%h", k, r_owe[st_start(3)+1+k], r_owa[st_start(3)+1+k], 32'h30C + k);
            else n_pass++;
        end
        for (int k = 4; k < 7; k++) begin
            n_checks++;
            if (r_ira[li_start(2)+k] !== 32'h208 + k) $display("FAIL i_raddr_blk2 k=%0d: got %h want %h", k, r_ira[li_start(2)+k], 32'h208 + k);
            else n_pass++;
        end
        nw = 0; ni = 0; no = 0; nd = 0; busy_bad = 0;
        for (int c = 1; c <= DONE_CYC + 1; c++) begin
            nw += int'(r_wwe[c]); ni += int'(r_iwe[c]); no += int'(r_owe[c]); nd += int'(r_done[c]);
            if (r_busy[c] !== (c < DONE_CYC)) busy_bad++;
        end
        n_checks++;
        if (nw !== W_WENS) $display("FAIL w_wen_count: got %0d want %0d", nw, W_WENS); else n_pass++;
        n_checks++;
        if (ni !== 28) $display("FAIL i_wen_count: got %0d want 28", ni); else n_pass++;
        n_checks++;
        if (no !== 16) $display("FAIL o_wen_count: got %0d want 16", no); else n_pass++;
        n_checks++;
        if (nd !== 1) $display("FAIL done_pulses: got %0d want 1", nd); else n_pass++;
        n_checks++;
        if (busy_bad !== 0) $display("FAIL busy_window: bad cycles %0d want 0", busy_bad); else n_pass++;
    endtask

    task automatic test_start_held;
        int c2;
        run_job(32'h1000, 32'h2000, 32'h3000, 1'b1, 2);
        n_checks++;
        if (done_cyc !== DONE_CYC) $display("FAIL held_done_cycle: got %0d want %0d", done_cyc, DONE_CYC); else n_pass++;
        n_checks++;
        if (r_ira[li_start(2)] !== 32'h2008) $display("FAIL held_i_raddr: got %h want 00002008", r_ira[li_start(2)]); else n_pass++;
        n_checks++;
        if (r_owa[st_start(3)+4] !== 32'h300F) $display("FAIL held_o_waddr: got %h want 0000300f", r_owa[st_start(3)+4]); else n_pass++;
        n_checks++;
        if (r_busy[DONE_CYC+1] !== 1'b0 || r_busy[DONE_CYC+2] !== 1'b1)
            $display("FAIL held_rearm: busy idle=%b next=%b want 0/1", r_busy[DONE_CYC+1], r_busy[DONE_CYC+2]);
        else n_pass++;
        start = 1'b0;
        c2 = 0;
        while (!done && c2 < 300) begin @(negedge clk); c2++; end
        n_checks++;
        if (!done) $display("FAIL held_second_job: done not seen after %0d cycles want done", c2); else n_pass++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job;
        int bad;
        @(negedge clk);
        W_Base = 32'h100; I_Base = 32'h200; O_Base = 32'h300; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL midjob_busy: got %b want 1", busy); else n_pass++;
        #2 aclr = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) $display("FAIL async_reset: outputs=%h want 0", all_out); else n_pass++;
        @(negedge clk);
        aclr = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy || done || ON_W_WEn || ON_I_WEn || OFF_O_WEn) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL post_reset_quiet: active cycles %0d want 0", bad); else n_pass++;
        run_job(32'h100, 32'h200, 32'h300, 1'b0, 1);
        n_checks++;
        if (done_cyc !== DONE_CYC) $display("FAIL post_reset_job: done %0d want %0d", done_cyc, DONE_CYC); else n_pass++;
    endtask

    task automatic test_wrap;
        logic [31:0] exp_a [0:3];
        exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
        run_job(32'h0, 32'h0, 32'hFFFFFFFE, 1'b0, 1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (r_owa[st_start(0)+1+k] !== exp_a[k])
                $display("FAIL wrap_o_waddr k=%0d: got %h want %h", k, r_owa[st_start(0)+1+k], exp_a[k]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_single_job;
        test_start_held;
        test_reset_mid_job;
        test_wrap;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
